// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store sequencer.
// Contents:
//   state_t  - sequencer FSM states
//   size_e   - access size decoded from funct3
//   F3_*     - RV32 load/store funct3 codes
//   f3_size  - funct3 -> access size (undefined codes 011/110/111 act as word)
package mem_access_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdIssue,
    StLdCapt,
    StStWrite,
    StRmwIssue,
    StRmwMerge,
    StRmwWrite
  } state_t;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic size_e f3_size(input logic [2:0] f3);
    size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SzByte;
      F3_H, F3_HU: sz = SzHalf;
      default:     sz = SzWord;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering between a 32-bit memory word and the datapath.
// Ports:
//   rdata_i      word read from memory (load source)
//   old_word_i   word read from memory (store merge base)
//   wdata_i      store data, meaningful bits in the low lanes
//   addr_lo_i    byte offset within the word
//   funct3_i     RV32 size/sign code
//   load_data_o  selected lane, sign- or zero-extended to 32 bits
//   merge_data_o old_word_i with the store lane(s) replaced by wdata_i
// Half accesses use addr_lo_i[1] only, so odd half addresses fold onto the aligned lane.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;
  size_e       size;

  assign size      = f3_size(funct3_i);
  assign ld_byte   = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign ld_half   = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
  // funct3[2] set marks the unsigned variants (BU/HU).
  assign ld_signed = ~funct3_i[2];

  always_comb begin
    load_data_o = rdata_i;
    case (size)
      SzByte:  load_data_o = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SzHalf:  load_data_o = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: load_data_o = rdata_i;
    endcase
  end

  always_comb begin
    merge_data_o = old_word_i;
    case (size)
      SzByte:  merge_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      SzHalf:  merge_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the multicycle datapath and a word-wide memory with a
// one-cycle registered read. Loads read a word and extract the lane; sub-word stores do a
// read-modify-write because the memory always writes all four bytes.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only when idle and not in reset)
//   req_we, req_funct3     store flag and RV32 size/sign code
//   req_addr, req_wdata    byte address and store data (low lanes)
//   resp_valid             one-cycle completion pulse
//   resp_rdata, resp_err   extended load data (0 for stores), misalign flag
//   mem_read, mem_write    state-decoded memory strobes, never both high
//   mem_addr, mem_wdata    word-aligned address and full write word
//   mem_rdata              read data, valid the cycle after mem_read
// Build option: define MEM_MISALIGN_TRAP_EN to reject misaligned H/W accesses with
// resp_err=1 one cycle after acceptance and no memory access. Without it resp_err stays 0
// and offending low address bits are ignored.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;

  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic              accept;
  logic              misalign;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] merge_word;

  assign req_ready = (state_q == StIdle) && !reset;
  assign accept    = req_valid && req_ready;

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (f3_size(req_funct3))
      SzHalf:  misalign = req_addr[0];
      SzWord:  misalign = (req_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Loads and the RMW read both sample mem_rdata; one aligner serves both paths.
  mem_lane_align u_lane_align (
    .rdata_i      (mem_rdata),
    .old_word_i   (mem_rdata),
    .wdata_i      (wdata_q),
    .addr_lo_i    (addr_q[1:0]),
    .funct3_i     (funct3_q),
    .load_data_o  (load_word),
    .merge_data_o (merge_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept && !misalign) begin
          if (!req_we) begin
            state_d = StLdIssue;
          end else if (f3_size(req_funct3) == SzWord) begin
            state_d = StStWrite;
          end else begin
            state_d = StRmwIssue;
          end
        end
      end
      StLdIssue:  state_d = StLdCapt;
      StLdCapt:   state_d = StIdle;
      StStWrite:  state_d = StIdle;
      StRmwIssue: state_d = StRmwMerge;
      StRmwMerge: state_d = StRmwWrite;
      StRmwWrite: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // State-decoded memory strobes.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      StLdIssue, StRmwIssue: mem_read  = 1'b1;
      StStWrite, StRmwWrite: mem_write = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = (state_q == StRmwWrite) ? merge_q : wdata_q;

  // Response for the following cycle; the pulse always lands while the FSM is in idle.
  always_comb begin
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      StIdle: begin
        if (accept && misalign) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end
      end
      StLdCapt: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_word;
      end
      StStWrite, StRmwWrite: resp_valid_d = 1'b1;
      default: ;
    endcase
  end

  // Request latch, merge register and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      funct3_q     <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      merge_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        we_q     <= req_we;
        wdata_q  <= req_wdata;
      end
      if (state_q == StRmwMerge) begin
        merge_q <= merge_word;
      end
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  // we_q is implied by the path the FSM took; it is kept with the latched request.
  logic unused_we;
  assign unused_we = we_q;

endmodule
